// File: rtl/bus_arbiter_pkg.sv
// Shared types and helpers for the round-robin bus arbiter.
package bus_arbiter_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'b001,
        GRANT = 3'b010,
        TURN  = 3'b100
    } state_t;

    // Next index after idx, wrapping to 0 past n-1.
    function automatic int unsigned wrap_inc(input int unsigned idx, input int unsigned n);
        if (idx + 32'd1 >= n) begin
            return 32'd0;
        end else begin
            return idx + 32'd1;
        end
    endfunction

endpackage

// File: rtl/bus_arbiter_if.sv
// Request/grant bundle between the bus masters and the arbiter.
interface bus_arbiter_if #(
    parameter int NUM_MASTERS = 4,
    parameter int ID_WIDTH    = 2
);
    logic [NUM_MASTERS-1:0] i_req;
    logic [NUM_MASTERS-1:0] o_grant;
    logic [ID_WIDTH-1:0]    o_grant_id;
    logic                   o_busy;
    logic                   o_timeout;
    logic [ID_WIDTH-1:0]    o_timeout_id;

    modport slave (
        input  i_req,
        output o_grant, o_grant_id, o_busy, o_timeout, o_timeout_id
    );

    modport master (
        output i_req,
        input  o_grant, o_grant_id, o_busy, o_timeout, o_timeout_id
    );
endinterface

// File: rtl/bus_arbiter_rr_picker.sv
// Combinational round-robin search: first eligible index at or after the pointer, wrapping.
module rr_picker #(
    parameter int NUM_MASTERS = 4,
    parameter int ID_WIDTH    = 2
) (
    input  logic [NUM_MASTERS-1:0] i_eligible,
    input  logic [ID_WIDTH-1:0]    i_ptr,
    output logic                   o_found,
    output logic [ID_WIDTH-1:0]    o_winner
);

    function automatic int rot(input int p, input int k);
        int s;
        s = p + k;
        if (s >= NUM_MASTERS) begin
            s = s - NUM_MASTERS;
        end else begin
            s = s;
        end
        return s;
    endfunction

    logic hit_s;

    // Scan offsets 0..N-1 from the pointer; the first eligible candidate wins.
    always_comb begin
        o_found  = 1'b0;
        o_winner = '0;
        hit_s    = 1'b0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            for (int j = 0; j < NUM_MASTERS; j++) begin
                hit_s    = !o_found && i_eligible[j] && (j == rot(int'(i_ptr), i));
                o_winner = hit_s ? ID_WIDTH'(j) : o_winner;
                o_found  = o_found | hit_s;
            end
        end
    end

endmodule

// File: rtl/bus_arbiter.sv
// Round-robin bus arbiter with one-cycle turnaround between owners and a hold-time watchdog.
module bus_arbiter
    import bus_arbiter_pkg::*;
#(
    parameter int NUM_MASTERS = 4,
    parameter int MAX_HOLD    = 16,
    parameter int ID_WIDTH    = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1
) (
    input  logic          clk,
    input  logic          rst,
    bus_arbiter_if.slave  bus
);

    localparam int CNT_W = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX   = (MAX_HOLD > 0) ? CNT_W'(MAX_HOLD) : CNT_W'(1);
    localparam logic [CNT_W-1:0] HOLD_LAST = (MAX_HOLD > 0) ? CNT_W'(MAX_HOLD - 1) : CNT_W'(0);
    localparam bit               WDOG_EN   = (MAX_HOLD > 0);

    state_t                 state_q, state_d;
    logic [ID_WIDTH-1:0]    ptr_q, ptr_d;
    logic [ID_WIDTH-1:0]    owner_q, owner_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [NUM_MASTERS-1:0] mask_q, mask_d;
    logic [NUM_MASTERS-1:0] grant_q, grant_d;
    logic                   busy_q, busy_d;
    logic                   timeout_q, timeout_d;
    logic [ID_WIDTH-1:0]    timeout_id_q, timeout_id_d;

    logic [NUM_MASTERS-1:0] eligible_s;
    logic                   found_s;
    logic [ID_WIDTH-1:0]    winner_s;
    logic                   owner_req_s;
    logic [ID_WIDTH-1:0]    next_ptr_s;

    assign eligible_s  = bus.i_req & ~mask_q;
    assign owner_req_s = bus.i_req[owner_q];
    assign next_ptr_s  = ID_WIDTH'(wrap_inc(32'(owner_q), 32'(NUM_MASTERS)));

    rr_picker #(
        .NUM_MASTERS (NUM_MASTERS),
        .ID_WIDTH    (ID_WIDTH)
    ) u_picker (
        .i_eligible (eligible_s),
        .i_ptr      (ptr_q),
        .o_found    (found_s),
        .o_winner   (winner_s)
    );

    // Next-state and next-output logic for the ownership FSM.
    always_comb begin
        state_d      = state_q;
        ptr_d        = ptr_q;
        owner_d      = owner_q;
        cnt_d        = cnt_q;
        mask_d       = mask_q & bus.i_req;
        grant_d      = '0;
        busy_d       = 1'b0;
        timeout_d    = 1'b0;
        timeout_id_d = timeout_id_q;
        case (state_q)
            IDLE, TURN: begin
                if (found_s) begin
                    state_d           = GRANT;
                    owner_d           = winner_s;
                    cnt_d             = '0;
                    grant_d[winner_s] = 1'b1;
                    busy_d            = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            GRANT: begin
                cnt_d = (cnt_q != CNT_MAX) ? cnt_q + CNT_W'(1) : cnt_q;
                // Release is checked first so a coinciding expiry never fires the watchdog.
                if (!owner_req_s) begin
                    state_d = TURN;
                    ptr_d   = next_ptr_s;
                end else if (WDOG_EN && (cnt_q == HOLD_LAST)) begin
                    state_d          = TURN;
                    ptr_d            = next_ptr_s;
                    timeout_d        = 1'b1;
                    timeout_id_d     = owner_q;
                    mask_d[owner_q]  = 1'b1;
                end else begin
                    grant_d = grant_q;
                    busy_d  = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, bookkeeping and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            ptr_q        <= '0;
            owner_q      <= '0;
            cnt_q        <= '0;
            mask_q       <= '0;
            grant_q      <= '0;
            busy_q       <= 1'b0;
            timeout_q    <= 1'b0;
            timeout_id_q <= '0;
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            owner_q      <= owner_d;
            cnt_q        <= cnt_d;
            mask_q       <= mask_d;
            grant_q      <= grant_d;
            busy_q       <= busy_d;
            timeout_q    <= timeout_d;
            timeout_id_q <= timeout_id_d;
        end
    end

    assign bus.o_grant      = grant_q;
    assign bus.o_grant_id   = owner_q;
    assign bus.o_busy       = busy_q;
    assign bus.o_timeout    = timeout_q;
    assign bus.o_timeout_id = timeout_id_q;

endmodule
